// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_e : arbiter FSM state (IDLE, BUSY_IF, BUSY_D, LOCKED)
//   owner_e     : which requester wins the current arbitration
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    LOCKED  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share a
// single memory port with at most one read outstanding.
//
// Ports:
//   clk, arst                     clock, asynchronous active-high reset
//   if_req_i/if_addr_i            fetch read request
//   if_gnt_o/if_rvalid_o/if_rdata_o  fetch grant and read return
//   d_req_i/d_we_i/d_mask_i/d_addr_i/d_wdata_i/d_lock_i  data request
//   d_gnt_o/d_rvalid_o/d_rdata_o  data grant and read return
//   mem_re_o/mem_we_o/mem_mask_o/mem_addr_o/mem_wdata_o  memory command
//   mem_rdata_i/mem_rresp_i       memory read return (one-cycle pulse)
//
// Build option: MEM_ARB_AMO_LOCK_EN -- when defined, a data grant with
// d_lock_i high keeps the port reserved for the data side (LOCKED state)
// until a data access with d_lock_i low completes. When undefined, d_lock_i
// is ignored and LOCKED is never entered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [3:0]            d_mask_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic                  d_lock_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_mask_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rresp_i
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_lock;       // data read in flight was a locked access

  logic   w_arb;
  logic   w_locked;
  logic   w_force;
  logic   w_resp;
  logic   w_d_lock;
  owner_e w_win;

`ifdef MEM_ARB_AMO_LOCK_EN
  assign w_d_lock = d_lock_i;
`else
  logic w_unused_lock;
  assign w_unused_lock = d_lock_i;
  assign w_d_lock      = 1'b0;
`endif

  assign w_arb    = (r_state == IDLE) || (r_state == LOCKED);
  assign w_locked = (r_state == LOCKED);
  // Starvation override is suppressed while the data side holds the lock.
  assign w_force  = (r_starve_cnt == LIMIT) && !w_locked;
  // Reset gates everything combinational so outputs drop the instant arst rises.
  assign w_resp   = mem_rresp_i && !arst;

  always_comb begin
    w_win = OWN_NONE;
    if (!arst && w_arb) begin
      if (w_locked) begin
        if (d_req_i) w_win = OWN_D;
      end else if (if_req_i && (w_force || !d_req_i)) begin
        w_win = OWN_IF;
      end else if (d_req_i) begin
        w_win = OWN_D;
      end
    end
  end

  always_comb begin
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_mask_o  = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (w_win)
      OWN_IF: begin
        if_gnt_o   = 1'b1;
        mem_re_o   = 1'b1;
        mem_mask_o = 4'hF;          // fetches always read the full word
        mem_addr_o = if_addr_i;
      end
      OWN_D: begin
        d_gnt_o    = 1'b1;
        mem_re_o   = !d_we_i;
        mem_we_o   = d_we_i;
        mem_mask_o = d_mask_i;
        mem_addr_o = d_addr_i;
        if (d_we_i) mem_wdata_o = d_wdata_i;
      end
      default: ;
    endcase
  end

  // Read data is only forwarded to the port that owns the outstanding read;
  // a response seen while not BUSY is dropped.
  assign if_rvalid_o = w_resp && (r_state == BUSY_IF);
  assign d_rvalid_o  = w_resp && (r_state == BUSY_D);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_lock       <= 1'b0;
    end else begin
      // A denial only happens at an arbitration point, so BUSY cycles do not
      // count toward starvation.
      if (!if_req_i || (w_win == OWN_IF)) begin
        r_starve_cnt <= '0;
      end else if (w_arb && (r_starve_cnt != LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      case (r_state)
        IDLE, LOCKED: begin
          case (w_win)
            OWN_IF: r_state <= BUSY_IF;
            OWN_D: begin
              r_lock <= w_d_lock;
              if (d_we_i) r_state <= w_d_lock ? LOCKED : IDLE;
              else        r_state <= BUSY_D;
            end
            default: ;
          endcase
        end
        BUSY_IF: if (mem_rresp_i) r_state <= IDLE;
        BUSY_D:  if (mem_rresp_i) r_state <= r_lock ? LOCKED : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          arst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i, d_we_i, d_lock_i;
  logic [3:0]    d_mask_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_gnt_o, d_rvalid_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_re_o, mem_we_o;
  logic [3:0]    mem_mask_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_rresp_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .arst(arst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_mask_i(d_mask_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_lock_i(d_lock_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_mask_o(mem_mask_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_rresp_i(mem_rresp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic e_if, input logic e_d);
    chk({tag, "_if_gnt"}, 64'(if_gnt_o), 64'(e_if));
    chk({tag, "_d_gnt"},  64'(d_gnt_o),  64'(e_d));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, 64'({if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_re_o,
                             mem_we_o, mem_mask_o}), 64'd0);
    chk({tag, "_addr"},  64'(mem_addr_o),  64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata_o), 64'd0);
    chk({tag, "_rdata"}, 64'({if_rdata_o, d_rdata_o}), 64'd0);
  endtask

  // Drive a read response for the given owner and compare against the scoreboard.
  task automatic respond(input string tag, input logic [DW-1:0] data, input owner_e own);
    logic [DW-1:0] e;
    mem_rresp_i = 1'b1;
    mem_rdata_i = data;
    exp_q.push_back(data);
    settle();
    e = exp_q.pop_front();
    chk({tag, "_if_rvalid"}, 64'(if_rvalid_o), 64'(own == OWN_IF));
    chk({tag, "_d_rvalid"},  64'(d_rvalid_o),  64'(own == OWN_D));
    chk({tag, "_rdata"}, 64'((own == OWN_IF) ? if_rdata_o : d_rdata_o), 64'(e));
    chk({tag, "_no_gnt"}, 64'({if_gnt_o, d_gnt_o}), 64'd0);
    step();
    mem_rresp_i = 1'b0;
    mem_rdata_i = '0;
  endtask

  initial begin
    arst = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_mask_i = 4'hF; d_addr_i = 32'h200;
    d_wdata_i = '0; d_lock_i = 1'b0;
    mem_rdata_i = 32'h5555_5555; mem_rresp_i = 1'b1;

    // Reset: all outputs low even with requests and a response present.
    step();
    settle();
    chk_all_zero("reset");
    mem_rresp_i = 1'b0; mem_rdata_i = '0;
    step();
    arst = 1'b0;

    // Both requesting: data wins, read command on memory port.
    settle();
    chk_grant("both", 1'b0, 1'b1);
    chk("both_addr", 64'(mem_addr_o), 64'h200);
    chk("both_re", 64'({mem_re_o, mem_we_o}), 64'b10);
    step();
    d_req_i = 1'b0;
    mem_rdata_i = 32'h7777_7777;
    settle();
    chk_grant("busy_d", 1'b0, 1'b0);
    chk("busy_d_re", 64'(mem_re_o), 64'd0);
    chk("busy_d_rdata0", 64'({d_rvalid_o, d_rdata_o}), 64'd0);
    step();
    respond("rd_dead", 32'hDEAD_BEEF, OWN_D);

    // Fetch alone is granted.
    settle();
    chk_grant("fetch", 1'b1, 1'b0);
    chk("fetch_addr", 64'(mem_addr_o), 64'h100);
    step();
    respond("rd_if", 32'h1234_5678, OWN_IF);

    // Starvation: four data reads win, the fifth arbitration goes to fetch.
    d_req_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d_addr_i = 32'h300 + 32'(4 * k);
      settle();
      chk_grant($sformatf("starve%0d", k), k == 4, k != 4);
      step();
      respond($sformatf("starve_rd%0d", k), 32'hA000_0000 + 32'(k), (k == 4) ? OWN_IF : OWN_D);
    end
    chk("starve_cnt_clr", 64'(dut.r_starve_cnt), 64'd0);
    settle();
    chk_grant("after_starve", 1'b0, 1'b1);
    d_req_i = 1'b0; if_req_i = 1'b0;
    step();

    // Data write: single-cycle strobe, fetch grantable next cycle, no rvalid.
    if_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b1;
    d_addr_i = 32'h40; d_wdata_i = 32'hCAFE_F00D; d_mask_i = 4'hF;
    settle();
    chk_grant("wr", 1'b0, 1'b1);
    chk("wr_strobe", 64'({mem_re_o, mem_we_o}), 64'b01);
    chk("wr_addr", 64'(mem_addr_o), 64'h40);
    chk("wr_data", 64'(mem_wdata_o), 64'hCAFE_F00D);
    chk("wr_mask", 64'(mem_mask_o), 64'hF);
    step();
    d_req_i = 1'b0; d_we_i = 1'b0; d_wdata_i = '0;
    settle();
    chk("wr_we_once", 64'(mem_we_o), 64'd0);
    chk("wr_no_rvalid", 64'(d_rvalid_o), 64'd0);
    chk_grant("wr_then_if", 1'b1, 1'b0);
    step();
    respond("wr_if_rd", 32'h0BAD_F00D, OWN_IF);

    // AMO: locked read then unlocked write with fetch pending.
    d_req_i = 1'b1; d_we_i = 1'b0; d_lock_i = 1'b1; d_addr_i = 32'h80;
    settle();
    chk_grant("amo_rd", 1'b0, 1'b1);
    step();
    d_req_i = 1'b0; d_lock_i = 1'b0;
    respond("amo_rdata", 32'h0000_0080, OWN_D);
    settle();
`ifdef MEM_ARB_AMO_LOCK_EN
    chk_grant("amo_gap", 1'b0, 1'b0);
    chk("amo_locked", 64'(dut.r_state), 64'(LOCKED));
    step();
`else
    chk_grant("amo_gap", 1'b1, 1'b0);
    step();
    respond("amo_gap_rd", 32'h0000_1111, OWN_IF);
`endif
    d_req_i = 1'b1; d_we_i = 1'b1; d_wdata_i = 32'h0000_0081;
    settle();
    chk_grant("amo_wr", 1'b0, 1'b1);
    chk("amo_wr_we", 64'(mem_we_o), 64'd1);
    step();
    d_req_i = 1'b0; d_we_i = 1'b0; d_wdata_i = '0;
    settle();
    chk_grant("amo_after", 1'b1, 1'b0);
    if_req_i = 1'b0;
    step();

    // Reset during BUSY_D, then the stale response arrives.
    d_req_i = 1'b1; d_addr_i = 32'h2C0;
    settle();
    chk_grant("rst_rd", 1'b0, 1'b1);
    step();
    if_req_i = 1'b1;
    arst = 1'b1;
    settle();
    chk_all_zero("rst_busy");
    chk("rst_state", 64'(dut.r_state), 64'(IDLE));
    if_req_i = 1'b0; d_req_i = 1'b0;
    step();
    arst = 1'b0;
    step();
    mem_rresp_i = 1'b1; mem_rdata_i = 32'hFEED_FACE;
    settle();
    chk_all_zero("rst_stale");
    step();
    mem_rresp_i = 1'b0;
    settle();
    chk("rst_stale_state", 64'(dut.r_state), 64'(IDLE));

    // Stray response in IDLE.
    mem_rresp_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
    settle();
    chk("stray_rvalid", 64'({if_rvalid_o, d_rvalid_o}), 64'd0);
    chk("stray_rdata", 64'({if_rdata_o, d_rdata_o}), 64'd0);
    step();
    mem_rresp_i = 1'b0;
    chk("stray_state", 64'(dut.r_state), 64'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
